// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one registered ALU among four requesters.
// Each granted operation walks IDLE -> ISSUE -> CAP_RES -> CAP_ZERO -> RESP.
module alu_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [32*NREQ-1:0]     req_a,
  input  logic [32*NREQ-1:0]     req_b,
  input  logic [4*NREQ-1:0]      req_opcode,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_opcode,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] CAP_RES  = 3'd2;
  localparam logic [2:0] CAP_ZERO = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  // First opcode the shared ALU does not implement.
  localparam logic [3:0] FIRST_ILLEGAL_OP = 4'd7;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [1:0]  prio_ptr;
  logic [1:0]  grant_idx;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [3:0]  lat_op;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;
  logic [15:0] op_count_q;

  logic [3:0]  rot_valid;
  logic [1:0]  pick_off;
  logic [1:0]  pick_idx;
  logic        grant_fire;
  logic        rsp_fire;
  logic        illegal_op;

  // Rotate requests so the current highest-priority requester sits at bit 0.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    rot_valid = 4'b0;
    pick_off  = 2'd0;
    case (prio_ptr)
      2'd0:    rot_valid = req_valid;
      2'd1:    rot_valid = {req_valid[0],   req_valid[3:1]};
      2'd2:    rot_valid = {req_valid[1:0], req_valid[3:2]};
      default: rot_valid = {req_valid[2:0], req_valid[3]};
    endcase
    if (rot_valid[0])      pick_off = 2'd0;
    else if (rot_valid[1]) pick_off = 2'd1;
    else if (rot_valid[2]) pick_off = 2'd2;
    else                   pick_off = 2'd3;
  end

  assign pick_idx   = prio_ptr + pick_off;
  // Gating with rst_n keeps req_ready low while reset is held even though state already reads IDLE.
  assign grant_fire = (state == IDLE) && (|req_valid) && rst_n;
  assign rsp_fire   = (state == RESP) && rsp_ready[grant_idx];
  assign illegal_op = (lat_op >= FIRST_ILLEGAL_OP);

  always_comb begin
    req_ready = 4'b0;
    if (grant_fire) req_ready = 4'b0001 << pick_idx;
  end

  always_comb begin
    rsp_valid = 4'b0;
    if (state == RESP) rsp_valid = 4'b0001 << grant_idx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_fire) state_nxt = ISSUE;
      ISSUE:    state_nxt = CAP_RES;
      CAP_RES:  state_nxt = CAP_ZERO;
      CAP_ZERO: state_nxt = RESP;
      RESP:     if (rsp_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio_ptr <= 2'd0;
    end else begin
      state <= state_nxt;
      if (grant_fire) prio_ptr <= pick_idx + 2'd1;
    end
  end

  // Operands stay latched from grant to the next grant so the ALU inputs never glitch mid-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx <= 2'd0;
      lat_a     <= 32'd0;
      lat_b     <= 32'd0;
      lat_op    <= 4'd0;
    end else if (grant_fire) begin
      grant_idx <= pick_idx;
      lat_a     <= req_a[{pick_idx, 5'd0} +: 32];
      lat_b     <= req_b[{pick_idx, 5'd0} +: 32];
      lat_op    <= req_opcode[{pick_idx, 2'd0} +: 4];
    end
  end

  // Result and zero flag arrive on consecutive cycles; unsupported opcodes report 0 / zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (state == CAP_RES)  rsp_result_q <= illegal_op ? 32'd0 : alu_result;
      if (state == CAP_ZERO) rsp_zero_q   <= illegal_op ? 1'b1  : alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= 16'd0;
    else if (rsp_fire) op_count_q <= op_count_q + 16'd1;
  end

  assign alu_a      = lat_a;
  assign alu_b      = lat_b;
  assign alu_opcode = lat_op;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model on the shared port.
// Inputs change after posedge; outputs are sampled on negedge (or #1 after posedge for counters).
module tb_alu_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_opcode;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_zero;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [3:0]   alu_opcode;
  logic [31:0]  alu_result = 32'd0;
  logic         alu_zero   = 1'b0;
  logic         busy;
  logic [15:0]  op_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  alu_arbiter #(.NREQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: result one cycle after operands, zero flag one cycle after result.
  // Unimplemented opcodes return a+b here so the arbiter's override is observable.
  always_ff @(posedge clk) begin
    case (alu_opcode)
      4'd0:    alu_result <= alu_a + alu_b;
      4'd1:    alu_result <= alu_a - alu_b;
      4'd2:    alu_result <= alu_a & alu_b;
      4'd3:    alu_result <= alu_a | alu_b;
      4'd4:    alu_result <= alu_a ^ alu_b;
      4'd5:    alu_result <= alu_a << alu_b[4:0];
      4'd6:    alu_result <= alu_a >> alu_b[4:0];
      default: alu_result <= alu_a + alu_b;
    endcase
    alu_zero <= (alu_result == 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_operands(input int r, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op);
    req_a[32*r +: 32]     = a;
    req_b[32*r +: 32]     = b;
    req_opcode[4*r +: 4]  = op;
  endtask

  // Waits for the grant to g (bounded), then follows the op through to its handshake.
  task automatic run_op(input int g, input logic [31:0] exp_a, input logic [3:0] exp_op,
                        input logic [31:0] exp_res, input logic exp_zero, input int hold,
                        input logic [3:0] hold_valid, input logic [3:0] valid_after);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready === 4'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("grant_r%0d", g), req_ready, 32'd1 << g);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("issue_busy", busy, 1);
    check("issue_alu_a", alu_a, exp_a);
    check("issue_alu_op", alu_opcode, exp_op);
    check("issue_no_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("capz_alu_a_hold", alu_a, exp_a);
    check("capz_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check($sformatf("rsp_valid_r%0d", g), rsp_valid, 32'd1 << g);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_zero", rsp_zero, exp_zero);
    if (hold > 0) begin
      req_valid = hold_valid;
      rsp_ready = ~(4'b0001 << g);
      repeat (hold) begin
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 32'd1 << g);
        check("bp_rsp_result", rsp_result, exp_res);
        check("bp_no_ready", req_ready, 0);
        check("bp_busy", busy, 1);
      end
    end
    rsp_ready = 4'b0001 << g;
    @(posedge clk);
    #1;
    rsp_ready = 4'b0;
    req_valid = valid_after;
    exp_cnt++;
    check("op_count", op_count, exp_cnt);
    check("back_idle", busy, 0);
  endtask

  initial begin
    logic [3:0] seen_rsp;
    rst_n      = 1'b0;
    req_valid  = 4'b0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 4'b0;

    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: 5 - 3 = 2
    set_operands(0, 32'd5, 32'd3, 4'd1);
    req_valid = 4'b0001;
    run_op(0, 32'd5, 4'd1, 32'd2, 1'b0, 0, 4'b0, 4'b0);

    // Zero result after a nonzero one: 7 ^ 7 = 0
    set_operands(2, 32'd7, 32'd7, 4'd4);
    req_valid = 4'b0100;
    run_op(2, 32'd7, 4'd4, 32'd0, 1'b1, 0, 4'b0, 4'b0);

    // Requester 3 moves the priority pointer back to 0: 0x10 << 1 = 0x20
    set_operands(3, 32'h10, 32'd1, 4'd5);
    req_valid = 4'b1000;
    run_op(3, 32'h10, 4'd5, 32'h20, 1'b0, 0, 4'b0, 4'b0);

    // Fairness: all four held high for eight ops
    set_operands(0, 32'd100, 32'd23, 4'd0);
    set_operands(1, 32'hF0, 32'h3C, 4'd2);
    set_operands(2, 32'h0F00, 32'h00F0, 4'd3);
    set_operands(3, 32'h80, 32'd3, 4'd6);
    req_valid = 4'b1111;
    for (int rep = 0; rep < 2; rep++) begin
      run_op(0, 32'd100, 4'd0, 32'h7B, 1'b0, 0, 4'b0, 4'b1111);
      run_op(1, 32'hF0, 4'd2, 32'h30, 1'b0, 0, 4'b0, 4'b1111);
      run_op(2, 32'h0F00, 4'd3, 32'h0FF0, 1'b0, 0, 4'b0, 4'b1111);
      run_op(3, 32'h80, 4'd6, 32'h10, 1'b0, 0, 4'b0, (rep == 1) ? 4'b0 : 4'b1111);
    end

    // Backpressure on requester 1 with every other input trying to interfere
    set_operands(1, 32'h1234, 32'h0234, 4'd1);
    req_valid = 4'b0010;
    run_op(1, 32'h1234, 4'd1, 32'h1000, 1'b0, 10, 4'b1111, 4'b0);

    // Reset during CAP_RES abandons the op
    set_operands(2, 32'd10, 32'd4, 4'd3);
    req_valid = 4'b0100;
    @(negedge clk);
    check("rstop_grant", req_ready, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_rsp_result", rsp_result, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_op", alu_opcode, 0);
    req_valid = 4'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 4'b0;
    repeat (8) begin
      @(negedge clk);
      seen_rsp = seen_rsp | rsp_valid;
    end
    check("postrst_no_rsp", seen_rsp, 0);
    check("postrst_op_count", op_count, 0);
    @(posedge clk);
    #1;

    // Priority pointer restarts at 0: requesters 1 and 3 pending, 1 wins; 9 - 2 = 7
    set_operands(1, 32'd9, 32'd2, 4'd1);
    set_operands(3, 32'd1, 32'd1, 4'd0);
    req_valid = 4'b1010;
    run_op(1, 32'd9, 4'd1, 32'd7, 1'b0, 0, 4'b0, 4'b0);

    // Unsupported opcode 9 is passed through but reports 0 / zero
    set_operands(2, 32'd1, 32'd1, 4'd9);
    req_valid = 4'b0100;
    run_op(2, 32'd1, 4'd9, 32'd0, 1'b1, 0, 4'b0, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one alu instance (fixed at 4; other values unsupported).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-requester operation request.
REQ-005 req_ready  output  4  per-requester accept strobe, one-hot or zero.
REQ-006 req_a, req_b  input  128 each  per-requester 32-bit operands; requester i uses bits [32i+31:32i].
REQ-007 req_opcode  input  16  per-requester 4-bit opcode; requester i uses bits [4i+3:4i].
REQ-008 rsp_valid  output  4  per-requester response valid, one-hot or zero.
REQ-009 rsp_ready  input  4  per-requester response accept.
REQ-010 rsp_result  output  32  result of the completed operation.
REQ-011 rsp_zero  output  1  zero flag of the completed operation.
REQ-012 alu_a, alu_b  output  32 each  operands driven to the shared alu.
REQ-013 alu_opcode  output  4  opcode driven to the shared alu.
REQ-014 alu_result  input  32  registered alu result (1-cycle latency).
REQ-015 alu_zero  input  1  registered alu zero flag (valid one cycle after alu_result).
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 op_count  output  16  count of completed response handshakes.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAP_RES, CAP_ZERO, RESP.
REQ-019 IDLE: if any req_valid is high, grant g per round-robin, assert req_ready[g] combinationally that cycle, latch req_a/req_b/req_opcode of g and g itself, go to ISSUE; else stay.
REQ-020 Round-robin: after reset, priority order 0,1,2,3; after grant to g, highest priority becomes (g+1) mod 4.
REQ-021 req_ready SHALL be high only in IDLE and only for the granted requester; dropping req_valid before grant has no effect.
REQ-022 alu_a/alu_b/alu_opcode SHALL equal latched values from ISSUE until the next grant, holding stable through CAP_RES and CAP_ZERO.
REQ-023 ISSUE -> CAP_RES unconditionally (alu registers result at end of ISSUE).
REQ-024 CAP_RES: capture alu_result into rsp_result register; go to CAP_ZERO.
REQ-025 CAP_ZERO: capture alu_zero into rsp_zero register; go to RESP.
REQ-026 RESP: rsp_valid[g] high, rsp_result/rsp_zero stable; on rsp_ready[g] high, go to IDLE and increment op_count (wraps 0xFFFF -> 0x0000).
REQ-027 rsp_ready of non-granted requesters and all req_valid SHALL be ignored outside IDLE/RESP as applicable; no new grant while RESP pending.
REQ-028 Latency: grant cycle T -> rsp_valid[g] first high at T+4; minimum spacing between grants 5 cycles.
REQ-029 Opcodes 7-15 SHALL be passed unchanged; response is result 0, zero 1.
REQ-030 Grant in the same cycle IDLE is re-entered SHALL NOT occur (RESP->IDLE takes a cycle).

Reset
REQ-031 On rst_n low, immediately: state IDLE, req_ready 0, rsp_valid 0, rsp_result 0, rsp_zero 0, alu_a/alu_b/alu_opcode 0, busy 0, op_count 0, priority pointer 0.
REQ-032 Reset mid-operation SHALL abandon the in-flight op with no response; after release, the requester must re-request.

Verification
REQ-033 Single op: req_valid=0001, a=5, b=3, opcode=1 -> req_ready[0] at T, rsp_valid[0] at T+4, rsp_result=2, rsp_zero=0, op_count=1.
REQ-034 Zero result: requester 2, a=7, b=7, opcode=4 -> rsp_result=0, rsp_zero=1 (not stale flag from prior nonzero op).
REQ-035 Fairness: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3, each response correct.
REQ-036 Backpressure: hold rsp_ready[1]=0 10 cycles in RESP -> rsp_valid[1], result stable, no new req_ready, busy=1.
REQ-037 Reset mid-op: rst_n low during CAP_RES -> all outputs reset values same cycle, no rsp_valid after release, op_count=0.
REQ-038 Illegal opcode 9 with a=1, b=1 -> rsp_result=0, rsp_zero=1.
